// File: rtl/mem_portb_arbiter_if.sv
// Port-B bus bundle: core and loader request channels plus the memory-side pins.
// The arbiter connects through the slave modport; requesters/memory model use master.
interface mem_portb_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              boot_mode;

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ready;
  logic [DATA_W-1:0] core_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  boot_mode,
    input  core_req, core_we, core_addr, core_wdata,
    output core_ready, core_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ready, ld_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output boot_mode,
    output core_req, core_we, core_addr, core_wdata,
    input  core_ready, core_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ready, ld_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/mem_portb_arbiter.sv
// Serialises core MEM-stage and UART-loader accesses onto memory port B with
// round-robin arbitration, boot-mode lockout and fully registered outputs.
module mem_portb_arbiter #(
  parameter int RD_LAT = 1,   // 1..4
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_portb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_CORE, OWN_LOADER} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              core_ready_q;
  logic              ld_ready_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;

  logic core_elig;
  logic ld_elig;
  logic grant_core;
  logic finish;
  logic capture;

  always_comb begin
    core_elig  = bus.core_req & ~bus.boot_mode;
    ld_elig    = bus.ld_req;
    // Contested grants go to whoever was not served last.
    grant_core = core_elig & (~ld_elig | (last_grant == OWN_LOADER));
    finish     = ((state == S_ISSUE) && (mem_we_q || (RD_LAT == 1))) ||
                 ((state == S_WAIT)  && (wait_cnt == 2'd1));
    capture    = finish & ~mem_we_q;
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      owner        <= OWN_CORE;
      last_grant   <= OWN_LOADER;
      wait_cnt     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      core_ready_q <= 1'b0;
      ld_ready_q   <= 1'b0;
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_elig || ld_elig) begin
            owner       <= grant_core ? OWN_CORE : OWN_LOADER;
            last_grant  <= grant_core ? OWN_CORE : OWN_LOADER;
            mem_addr_q  <= grant_core ? bus.core_addr  : bus.ld_addr;
            mem_wdata_q <= grant_core ? bus.core_wdata : bus.ld_wdata;
            mem_we_q    <= grant_core ? bus.core_we    : bus.ld_we;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_we_q <= 1'b0;
          if (finish) begin
            state <= S_DONE;
          end else begin
            wait_cnt <= 2'(RD_LAT - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finish) state <= S_DONE;
          else        wait_cnt <= wait_cnt - 2'd1;
        end
        S_DONE: state <= S_IDLE;
      endcase

      core_ready_q <= finish && (owner == OWN_CORE);
      ld_ready_q   <= finish && (owner == OWN_LOADER);
      // Read data is only refreshed for reads; writes leave the last value in place.
      if (capture && (owner == OWN_CORE))   core_rdata_q <= bus.mem_rdata;
      if (capture && (owner == OWN_LOADER)) ld_rdata_q   <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.core_ready = core_ready_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.ld_ready   = ld_ready_q;
  assign bus.ld_rdata   = ld_rdata_q;

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Bench for mem_portb_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus,
// only one is out of reset at a time; a word memory sits behind both.
module tb_mem_portb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  mem_portb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_portb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_portb_arbiter #(.RD_LAT(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_portb_arbiter #(.RD_LAT(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (.clk(clk), .rst(rst3), .bus(b3));

  logic        boot_mode, core_req, core_we, ld_req, ld_we;
  logic [31:0] core_addr, core_wdata, ld_addr, ld_wdata;

  assign b1.boot_mode = boot_mode;  assign b3.boot_mode = boot_mode;
  assign b1.core_req = core_req;    assign b3.core_req = core_req;
  assign b1.core_we = core_we;      assign b3.core_we = core_we;
  assign b1.core_addr = core_addr;  assign b3.core_addr = core_addr;
  assign b1.core_wdata = core_wdata; assign b3.core_wdata = core_wdata;
  assign b1.ld_req = ld_req;        assign b3.ld_req = ld_req;
  assign b1.ld_we = ld_we;          assign b3.ld_we = ld_we;
  assign b1.ld_addr = ld_addr;      assign b3.ld_addr = ld_addr;
  assign b1.ld_wdata = ld_wdata;    assign b3.ld_wdata = ld_wdata;

  // Memory behind port B and the bench's own expectation of its contents.
  bit [31:0] mem   [0:255];
  bit [31:0] model [0:255];
  bit        poke;
  bit [7:0]  poke_idx;
  bit [31:0] poke_val;

  assign b1.mem_rdata = mem[b1.mem_addr[9:2]];
  assign b3.mem_rdata = mem[b3.mem_addr[9:2]];

  always @(posedge clk) begin
    if (poke) mem[poke_idx] = poke_val;
    if (b1.mem_we === 1'b1) mem[b1.mem_addr[9:2]] = b1.mem_wdata;
    if (b3.mem_we === 1'b1) mem[b3.mem_addr[9:2]] = b3.mem_wdata;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        core_ready;
    logic [31:0] core_rdata;
    logic        ld_ready;
    logic [31:0] ld_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
  } obs_t;

  function automatic obs_t observe(input bit on3);
    obs_t o;
    if (on3) begin
      o.core_ready = b3.core_ready; o.core_rdata = b3.core_rdata;
      o.ld_ready   = b3.ld_ready;   o.ld_rdata   = b3.ld_rdata;
      o.mem_addr   = b3.mem_addr;   o.mem_wdata  = b3.mem_wdata; o.mem_we = b3.mem_we;
    end else begin
      o.core_ready = b1.core_ready; o.core_rdata = b1.core_rdata;
      o.ld_ready   = b1.ld_ready;   o.ld_rdata   = b1.ld_rdata;
      o.mem_addr   = b1.mem_addr;   o.mem_wdata  = b1.mem_wdata; o.mem_we = b1.mem_we;
    end
    return o;
  endfunction

  function automatic bit is_zero(input obs_t o);
    return (o.core_ready === 1'b0) && (o.core_rdata === 32'h0) && (o.ld_ready === 1'b0) &&
           (o.ld_rdata === 32'h0) && (o.mem_addr === 32'h0) && (o.mem_wdata === 32'h0) &&
           (o.mem_we === 1'b0);
  endfunction

  // Small address pool so reads regularly hit locations written earlier.
  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a       = $urandom;
    a[9:2]  = 8'h80 | 8'($urandom_range(0, 3));
    a[1:0]  = 2'b00;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    boot_mode = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ld_req   = 1'b0; ld_we   = 1'b0; ld_addr   = '0; ld_wdata   = '0;
  endtask

  task automatic poke_mem(input logic [31:0] addr, input logic [31:0] val);
    poke_idx = addr[9:2]; poke_val = val; poke = 1'b1;
    tick();
    poke = 1'b0;
    model[addr[9:2]] = val;
  endtask

  // Run one transaction on an idle arbiter; called in an IDLE cycle, returns in the next IDLE cycle.
  task automatic access(input bit on3, input bit is_core, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata, input string name);
    obs_t        o;
    int          n;
    int          want_n;
    bit          got;
    logic        own_rdy, oth_rdy;
    logic [31:0] rd;
    want_n = we ? 2 : 1 + (on3 ? 3 : 1);
    if (is_core) begin core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; end
    else         begin ld_req   = 1'b1; ld_we   = we; ld_addr   = addr; ld_wdata   = wdata; end
    got = 1'b0;
    n   = 0;
    while (!got && n < 12) begin
      tick();
      n++;
      o = observe(on3);
      total++;
      if (n == 1) begin
        if (o.mem_addr !== addr || o.mem_we !== we || (we && o.mem_wdata !== wdata)) begin
          bad++;
          $display("FAIL %s issue: mem_addr=%h mem_we=%b mem_wdata=%h, want %h %b %h",
                   name, o.mem_addr, o.mem_we, o.mem_wdata, addr, we, wdata);
        end
      end else if (o.mem_we !== 1'b0) begin
        bad++;
        $display("FAIL %s mem_we outside issue (cycle %0d): got %b want 0", name, n, o.mem_we);
      end
      own_rdy = is_core ? o.core_ready : o.ld_ready;
      oth_rdy = is_core ? o.ld_ready   : o.core_ready;
      rd      = is_core ? o.core_rdata : o.ld_rdata;
      total++;
      if (oth_rdy !== 1'b0) begin
        bad++;
        $display("FAIL %s other ready: got %b want 0", name, oth_rdy);
      end
      if (own_rdy === 1'b1) begin
        got = 1'b1;
        total++;
        if (n != want_n) begin
          bad++;
          $display("FAIL %s latency: got %0d want %0d", name, n, want_n);
        end
        if (!we) begin
          total++;
          if (rd !== model[addr[9:2]]) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", name, rd, model[addr[9:2]]);
          end
        end else begin
          model[addr[9:2]] = wdata;
        end
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s timeout: no ready after %0d cycles, want %0d", name, n, want_n);
    end
    core_req = 1'b0; ld_req = 1'b0;
    tick();
    o = observe(on3);
    total++;
    if (o.core_ready !== 1'b0 || o.ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse width: ready still %b/%b want 0/0", name, o.core_ready, o.ld_ready);
    end
  endtask

  // Core issues reads, loader issues writes, both re-requesting in their ready cycle.
  task automatic traffic(input int core_n, input int ld_n, input bit boot_init,
                         input int drop_at, input string exp_seq, input string name);
    obs_t o;
    int   pos, last, cyc, core_left, ld_left;
    byte  ch;
    boot_mode = boot_init;
    core_left = core_n;
    ld_left   = ld_n;
    if (core_left > 0) begin core_req = 1'b1; core_we = 1'b0; core_addr = rand_addr(); end
    if (ld_left > 0)   begin ld_req = 1'b1; ld_we = 1'b1; ld_addr = rand_addr(); ld_wdata = $urandom; end
    pos = 0; last = 0; cyc = 0;
    while (pos < exp_seq.len() && cyc < 100) begin
      tick();
      cyc++;
      o = observe(1'b0);
      if (boot_mode && drop_at >= 0 && o.mem_we === 1'b1 && (ld_n - ld_left) == drop_at)
        boot_mode = 1'b0;
      total++;
      if (o.core_ready === 1'b1 && o.ld_ready === 1'b1) begin
        bad++;
        $display("FAIL %s overlap at cycle %0d: core_ready=1 ld_ready=1, want one", name, cyc);
      end
      if (o.core_ready === 1'b1 || o.ld_ready === 1'b1) begin
        ch = (o.core_ready === 1'b1) ? 8'h43 : 8'h4C;
        total++;
        if (ch != exp_seq[pos]) begin
          bad++;
          $display("FAIL %s grant %0d: got %c want %c", name, pos, ch, exp_seq[pos]);
        end
        total++;
        if (cyc - last != (pos == 0 ? 2 : 3)) begin
          bad++;
          $display("FAIL %s spacing %0d: got %0d want %0d", name, pos, cyc - last, pos == 0 ? 2 : 3);
        end
        last = cyc;
        pos++;
        if (o.core_ready === 1'b1) begin
          total++;
          if (o.core_rdata !== model[core_addr[9:2]]) begin
            bad++;
            $display("FAIL %s core_rdata: got %h want %h", name, o.core_rdata, model[core_addr[9:2]]);
          end
          core_left--;
          if (core_left > 0) core_addr = rand_addr();
          else               core_req  = 1'b0;
        end else begin
          model[ld_addr[9:2]] = ld_wdata;
          ld_left--;
          if (ld_left > 0) begin ld_addr = rand_addr(); ld_wdata = $urandom; end
          else             ld_req = 1'b0;
        end
      end
    end
    total++;
    if (pos != exp_seq.len()) begin
      bad++;
      $display("FAIL %s timeout: got %0d pulses want %0d", name, pos, exp_seq.len());
    end
    idle_inputs();
    tick();
  endtask

  task automatic select_dut(input bit on3);
    idle_inputs();
    rst1 = on3;
    rst3 = !on3;
    tick();
    tick();
  endtask

  task automatic test_reset();
    obs_t o;
    rst1 = 1'b1; rst3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      boot_mode = 1'($urandom); core_req = 1'($urandom); core_we = 1'($urandom);
      core_addr = $urandom; core_wdata = $urandom;
      ld_req = 1'($urandom); ld_we = 1'($urandom); ld_addr = $urandom; ld_wdata = $urandom;
      tick();
      for (int k = 0; k < 2; k++) begin
        o = observe(k[0]);
        total++;
        if (!is_zero(o)) begin
          bad++;
          $display("FAIL reset dut%0d: ready=%b/%b mem_we=%b mem_addr=%h, want all 0",
                   k, o.core_ready, o.ld_ready, o.mem_we, o.mem_addr);
        end
      end
    end
    idle_inputs();
    rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = observe(1'b0);
      total++;
      if (!is_zero(o)) begin
        bad++;
        $display("FAIL post_reset cycle %0d: mem_we=%b mem_addr=%h ready=%b/%b, want all 0",
                 i, o.mem_we, o.mem_addr, o.core_ready, o.ld_ready);
      end
    end
  endtask

  task automatic test_core_read();
    poke_mem(32'h0000_0100, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "core_read");
  endtask

  task automatic test_loader_write();
    access(1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, "ld_write");
  endtask

  task automatic test_back_to_back();
    traffic(4, 4, 1'b0, -1, "CLCLCLCL", "contention");
  endtask

  task automatic test_boot_mode();
    traffic(1, 6, 1'b1, 4, "LLLLLCL", "boot_mode");
  endtask

  task automatic test_reset_in_wait();
    obs_t        o;
    logic [31:0] a;
    select_dut(1'b1);
    a = rand_addr();
    poke_mem(a, $urandom | 32'h1);
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    tick();
    o = observe(1'b1);
    total++;
    if (o.mem_addr !== a || o.core_ready !== 1'b0) begin
      bad++;
      $display("FAIL lat3 issue: mem_addr=%h ready=%b want %h 0", o.mem_addr, o.core_ready, a);
    end
    tick();
    o = observe(1'b1);
    total++;
    if (o.core_ready !== 1'b0) begin
      bad++;
      $display("FAIL lat3 wait ready: got %b want 0", o.core_ready);
    end
    rst3 = 1'b1;
    core_req = 1'b0;
    tick();
    rst3 = 1'b0;
    o = observe(1'b1);
    total++;
    if (!is_zero(o)) begin
      bad++;
      $display("FAIL lat3 reset in wait: ready=%b mem_addr=%h rdata=%h want all 0",
               o.core_ready, o.mem_addr, o.core_rdata);
    end
    tick();
    o = observe(1'b1);
    total++;
    if (!is_zero(o)) begin
      bad++;
      $display("FAIL lat3 after reset: ready=%b mem_addr=%h want all 0", o.core_ready, o.mem_addr);
    end
    access(1'b1, 1'b1, 1'b0, a, 32'h0, "lat3_reissue");
  endtask

  task automatic test_random(input bit on3, input int n);
    bit          is_core, we;
    logic [31:0] a, d;
    for (int i = 0; i < n; i++) begin
      is_core = 1'($urandom);
      we      = 1'($urandom);
      a       = rand_addr();
      d       = $urandom;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      access(on3, is_core, we, a, d, on3 ? "rand_lat3" : "rand_lat1");
    end
  endtask

  initial begin
    poke = 1'b0;
    idle_inputs();
    test_reset();
    test_core_read();
    test_loader_write();
    test_back_to_back();
    test_boot_mode();
    test_reset_in_wait();
    test_random(1'b1, 12);
    select_dut(1'b0);
    test_random(1'b0, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
